pos_input_ring_node: RTL and testbench
======================================

// Module: pos_input_ring_node
// PURPOSE
//  One node of the position-distribution ring. Forwards in-flight particle position packets
//  from the previous node to the next node, decrementing their lifetime. Injects local
//  position-cache packets into empty ring slots. Hands every packet whose cell neighbours
//  this node's home cell (GCELL_X/Y/Z) to the local PE dispatcher.
// PARAMETERS
//  GCELL_X              3'b000  home cell X coordinate (GLOBAL_CELL_ID_WIDTH bits)
//  GCELL_Y              3'b000  home cell Y coordinate
//  GCELL_Z              3'b000  home cell Z coordinate
//  LIFETIME_INIT        13      lifetime (hop count) given to an injected packet
//  Package widths (MD_pkg): GLOBAL_CELL_ID_WIDTH=3, NB_CELL_COUNT_WIDTH=5, offset 23b/axis,
//  parid PARID_WIDTH, element 2b
// PORTS
//  clk                         in   1     clock
//  rst                         in   1     synchronous active-high reset
//  i_source_offset_pkt         in   offset_packet_t  packet from previous node {offset{x,y,z},parid,element}
//  i_source_gcid               in   9     cell id {x,y,z} of source packet, x in MSBs
//  i_source_lifetime           in   5     remaining hops; 0 = empty slot (acts as valid)
//  i_local_offset_pkt          in   offset_packet_t  packet from local pos cache
//  i_local_gcid                in   9     cell id of local packet
//  i_local_valid               in   1     local packet present
//  i_local_dirty               in   1     local packet already sent; never inject
//  i_dispatcher_back_pressure  in   1     blocks local injection only
//  o_offset_pkt_to_ring        out  offset_packet_t  to next node
//  o_gcid_to_ring              out  9     to next node
//  o_lifetime_to_ring          out  5     to next node; 0 = empty slot
//  o_pos_pkt_to_pe             out  pos_packet_t {gcid, offset_packet_t}
//  o_pos_pkt_to_pe_valid       out  1     o_pos_pkt_to_pe valid this cycle
//  o_dirty_feedback            out  1     local packet accepted; cache marks entry dirty
// BEHAVIOUR
//  - Single clock clk, synchronous active-high rst. On rst all registered outputs are 0, and
//    o_dirty_feedback is forced to 0.
//  - Slot select, combinational, evaluated each cycle:
//    - fwd = i_source_lifetime != 0.
//    - inj = !fwd & i_local_valid & !i_local_dirty & !i_dispatcher_back_pressure.
//    - Ring traffic always has priority over local injection.
//  - fwd: next ring outputs = source pkt/gcid, lifetime = i_source_lifetime-1.
//    A packet arriving with lifetime 1 leaves with 0, which frees the slot downstream.
//  - inj: next ring outputs = local pkt/gcid, lifetime = LIFETIME_INIT.
//  - Neither: ring outputs pkt=0, gcid=0, lifetime=0.
//  - PE delivery: the packet chosen this cycle (fwd or inj) is also registered into
//    o_pos_pkt_to_pe. o_pos_pkt_to_pe_valid=1 iff its gcid neighbours the home cell.
//    Otherwise valid=0 and o_pos_pkt_to_pe is held.
//  - Neighbour test: per axis d = (pkt_coord - GCELL_coord) mod 8, with 3-bit wrap-around.
//    Neighbour iff every axis d is in {0,1,7}, i.e. 27-cell shell including home.
//  - Latency: 1 cycle, input to all registered outputs. No stall of ring traffic.
//    Back pressure never blocks or drops forwarded packets.
//  - o_dirty_feedback = inj, combinational and same-cycle. Repeats every cycle the cache
//    holds a clean valid entry and the slot is free.
//  - Reset mid-operation: in-flight registered packet discarded; outputs 0 the next edge.
// CONFIGURATION
//  POS_RING_HALF_SHELL_EN defined: the neighbour test accepts only the 14-cell half shell:
//    dx=1 (any dy,dz), or dx=0 & dy=1 (any dz), or dx=0 & dy=0 & dz in {0,1}.
//  Not defined: the full 27-cell test above. Ring forwarding is identical in both builds.
// TESTING
//  1. rst=1 for 10 cycles, all inputs 0 -> every output 0.
//  2. Local valid=1, dirty=0, gcid=0, parid=1, offsets 1/2/3, source lifetime 0:
//     - o_dirty_feedback=1 same cycle.
//     - Next cycle: lifetime=13, gcid=0, parid=1, pe_valid=1.
//  3. Local dirty=1, parid=2, gcid=9'b000000010 -> no injection, feedback=0, lifetime_to_ring=0.
//  4. Source lifetime=10, gcid=9'b111111111, local valid clean:
//     - Forward with lifetime 9, feedback=0.
//     - pe_valid=1, since (-1,-1,-1) wraps into the shell; 0 under POS_RING_HALF_SHELL_EN.
//  5. Source lifetime=1, gcid=9'b011000000 (x=3) -> out lifetime 0, pe_valid=0;
//     next free cycle injects local packet.
//  6. Back pressure=1 with empty slot and clean local packet -> no injection, feedback=0;
//     a simultaneous source packet with lifetime 5 is still forwarded with lifetime 4.

Source files
------------

// File: rtl/pos_input_ring_node.sv
// Position-ring node: forwards ring packets, injects local packets into free slots and
// delivers neighbouring-cell packets to the PE. Define POS_RING_HALF_SHELL_EN for the 14-cell half shell.
module pos_input_ring_node #(
    parameter logic [2:0]   GCELL_X       = 3'b000,
    parameter logic [2:0]   GCELL_Y       = 3'b000,
    parameter logic [2:0]   GCELL_Z       = 3'b000,
    parameter int unsigned  LIFETIME_INIT = 13,
    parameter int unsigned  PARID_WIDTH   = 8,
    localparam int unsigned OFFSET_WIDTH     = 23,
    localparam int unsigned OFFSET_PKT_WIDTH = 3*OFFSET_WIDTH + PARID_WIDTH + 2,
    localparam int unsigned POS_PKT_WIDTH    = 9 + OFFSET_PKT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [OFFSET_PKT_WIDTH-1:0] i_source_offset_pkt,
    input  logic [8:0]                  i_source_gcid,
    input  logic [4:0]                  i_source_lifetime,
    input  logic [OFFSET_PKT_WIDTH-1:0] i_local_offset_pkt,
    input  logic [8:0]                  i_local_gcid,
    input  logic                        i_local_valid,
    input  logic                        i_local_dirty,
    input  logic                        i_dispatcher_back_pressure,
    output logic [OFFSET_PKT_WIDTH-1:0] o_offset_pkt_to_ring,
    output logic [8:0]                  o_gcid_to_ring,
    output logic [4:0]                  o_lifetime_to_ring,
    output logic [POS_PKT_WIDTH-1:0]    o_pos_pkt_to_pe,
    output logic                        o_pos_pkt_to_pe_valid,
    output logic                        o_dirty_feedback
);

    logic                        fwd;
    logic                        inj;
    logic [OFFSET_PKT_WIDTH-1:0] ring_pkt_d, ring_pkt_q;
    logic [8:0]                  ring_gcid_d, ring_gcid_q;
    logic [4:0]                  ring_lifetime_d, ring_lifetime_q;
    logic [POS_PKT_WIDTH-1:0]    pe_pkt_d, pe_pkt_q;
    logic                        pe_valid_d, pe_valid_q;

    function automatic logic near(input logic [2:0] d);
        return (d == 3'd0) || (d == 3'd1) || (d == 3'd7);
    endfunction

    // Per-axis distance wraps modulo 8, so 3'd7 is the -1 neighbour.
    function automatic logic is_neighbour(input logic [8:0] gcid);
        logic [2:0] dx, dy, dz;
        dx = gcid[8:6] - GCELL_X;
        dy = gcid[5:3] - GCELL_Y;
        dz = gcid[2:0] - GCELL_Z;
`ifdef POS_RING_HALF_SHELL_EN
        return ((dx == 3'd1) && near(dy) && near(dz))
            || ((dx == 3'd0) && (dy == 3'd1) && near(dz))
            || ((dx == 3'd0) && (dy == 3'd0) && ((dz == 3'd0) || (dz == 3'd1)));
`else
        return near(dx) && near(dy) && near(dz);
`endif
    endfunction

    always_comb begin
        fwd             = (i_source_lifetime != '0);
        inj             = !fwd && i_local_valid && !i_local_dirty && !i_dispatcher_back_pressure;
        ring_pkt_d      = '0;
        ring_gcid_d     = '0;
        ring_lifetime_d = '0;
        if (fwd) begin
            ring_pkt_d      = i_source_offset_pkt;
            ring_gcid_d     = i_source_gcid;
            ring_lifetime_d = i_source_lifetime - 5'd1;
        end else if (inj) begin
            ring_pkt_d      = i_local_offset_pkt;
            ring_gcid_d     = i_local_gcid;
            ring_lifetime_d = 5'(LIFETIME_INIT);
        end
        pe_valid_d = (fwd || inj) && is_neighbour(ring_gcid_d);
        pe_pkt_d   = pe_valid_d ? {ring_gcid_d, ring_pkt_d} : pe_pkt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_pkt_q      <= '0;
            ring_gcid_q     <= '0;
            ring_lifetime_q <= '0;
            pe_pkt_q        <= '0;
            pe_valid_q      <= 1'b0;
        end else begin
            ring_pkt_q      <= ring_pkt_d;
            ring_gcid_q     <= ring_gcid_d;
            ring_lifetime_q <= ring_lifetime_d;
            pe_pkt_q        <= pe_pkt_d;
            pe_valid_q      <= pe_valid_d;
        end
    end

    assign o_offset_pkt_to_ring  = ring_pkt_q;
    assign o_gcid_to_ring        = ring_gcid_q;
    assign o_lifetime_to_ring    = ring_lifetime_q;
    assign o_pos_pkt_to_pe       = pe_pkt_q;
    assign o_pos_pkt_to_pe_valid = pe_valid_q;
    assign o_dirty_feedback      = inj && !rst;

endmodule

// File: tb/tb_pos_input_ring_node.sv
// Bench for pos_input_ring_node: directed vector table, reset sequences and random traffic
// checked against a reference model built from the forwarding/injection/neighbour rules.
module tb_pos_input_ring_node;

    localparam int unsigned PW        = 8;
    localparam int unsigned OPW       = 3*23 + PW + 2;
    localparam int unsigned PPW       = 9 + OPW;
    localparam int unsigned LIFE_INIT = 13;
    localparam int          GX = 0, GY = 0, GZ = 0;
`ifdef POS_RING_HALF_SHELL_EN
    localparam bit HALF = 1'b1;
`else
    localparam bit HALF = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]    src_life;
        logic [8:0]    src_gcid;
        logic [PW-1:0] src_parid;
        logic          loc_valid;
        logic          loc_dirty;
        logic          bp;
        logic [8:0]    loc_gcid;
        logic [PW-1:0] loc_parid;
        logic          exp_fb;
        logic [4:0]    exp_life;
        logic [8:0]    exp_gcid;
        logic [PW-1:0] exp_parid;
        logic          exp_pev;
        logic [8:0]    exp_pe_gcid;
        logic [PW-1:0] exp_pe_parid;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [OPW-1:0] src_pkt, loc_pkt;
    logic [8:0]     src_gcid, loc_gcid;
    logic [4:0]     src_life;
    logic           loc_valid, loc_dirty, bp;
    logic [OPW-1:0] o_offset_pkt_to_ring;
    logic [8:0]     o_gcid_to_ring;
    logic [4:0]     o_lifetime_to_ring;
    logic [PPW-1:0] o_pos_pkt_to_pe;
    logic           o_pos_pkt_to_pe_valid;
    logic           o_dirty_feedback;

    int total = 0;
    int bad   = 0;
    logic obs_fb;

    // reference model state
    logic [OPW-1:0] m_pkt;
    logic [8:0]     m_gcid;
    logic [4:0]     m_life;
    logic [PPW-1:0] m_pe;
    logic           m_pev;

    vec_t vecs [9];

    always #5 clk = ~clk;

    pos_input_ring_node #(
        .GCELL_X(3'(GX)), .GCELL_Y(3'(GY)), .GCELL_Z(3'(GZ)),
        .LIFETIME_INIT(LIFE_INIT), .PARID_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_source_offset_pkt(src_pkt), .i_source_gcid(src_gcid), .i_source_lifetime(src_life),
        .i_local_offset_pkt(loc_pkt), .i_local_gcid(loc_gcid), .i_local_valid(loc_valid),
        .i_local_dirty(loc_dirty), .i_dispatcher_back_pressure(bp),
        .o_offset_pkt_to_ring(o_offset_pkt_to_ring), .o_gcid_to_ring(o_gcid_to_ring),
        .o_lifetime_to_ring(o_lifetime_to_ring), .o_pos_pkt_to_pe(o_pos_pkt_to_pe),
        .o_pos_pkt_to_pe_valid(o_pos_pkt_to_pe_valid), .o_dirty_feedback(o_dirty_feedback)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OPW-1:0] mk_pkt(input int ox, input int oy, input int oz, input logic [PW-1:0] parid);
        return {23'(ox), 23'(oy), 23'(oz), parid, 2'd0};
    endfunction

    function automatic logic [OPW-1:0] rand_pkt();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[OPW-1:0];
    endfunction

    function automatic logic [2:0] rand_coord();
        int k;
        if ($urandom_range(0, 1) == 0) return 3'($urandom_range(0, 7));
        k = int'($urandom_range(0, 2));
        return (k == 2) ? 3'd7 : 3'(k);
    endfunction

    // Signed per-axis offsets in {-1,0,1}; the half shell is the lexicographically non-negative half.
    function automatic bit model_nb(input logic [8:0] g);
        int c [3];
        int h [3];
        int s [3];
        int d;
        c = '{int'(g[8:6]), int'(g[5:3]), int'(g[2:0])};
        h = '{GX, GY, GZ};
        for (int i = 0; i < 3; i++) begin
            d = (c[i] - h[i] + 8) % 8;
            if (d == 7) s[i] = -1;
            else if (d <= 1) s[i] = d;
            else return 1'b0;
        end
        if (HALF) return (s[0]*9 + s[1]*3 + s[2]) >= 0;
        return 1'b1;
    endfunction

    task automatic step(input string tag);
        logic           fwd, inj;
        logic [OPW-1:0] p;
        logic [8:0]     g;
        #2;
        fwd    = (src_life != 5'd0);
        inj    = !fwd && loc_valid && !loc_dirty && !bp && !rst;
        obs_fb = o_dirty_feedback;
        check({tag, "/fb"}, 128'(obs_fb), 128'(inj));
        if (rst) begin
            m_pkt = '0; m_gcid = '0; m_life = '0; m_pe = '0; m_pev = 1'b0;
        end else begin
            p = fwd ? src_pkt : loc_pkt;
            g = fwd ? src_gcid : loc_gcid;
            if (fwd) begin
                m_pkt = p; m_gcid = g; m_life = src_life - 5'd1;
            end else if (inj) begin
                m_pkt = p; m_gcid = g; m_life = 5'(LIFE_INIT);
            end else begin
                m_pkt = '0; m_gcid = '0; m_life = '0;
            end
            m_pev = (fwd || inj) && model_nb(g);
            if (m_pev) m_pe = {g, p};
        end
        @(posedge clk);
        #1;
        check({tag, "/ring_pkt"},  128'(o_offset_pkt_to_ring),  128'(m_pkt));
        check({tag, "/ring_gcid"}, 128'(o_gcid_to_ring),        128'(m_gcid));
        check({tag, "/ring_life"}, 128'(o_lifetime_to_ring),    128'(m_life));
        check({tag, "/pe_pkt"},    128'(o_pos_pkt_to_pe),       128'(m_pe));
        check({tag, "/pe_valid"},  128'(o_pos_pkt_to_pe_valid), 128'(m_pev));
    endtask

    task automatic drive_zero();
        src_pkt = '0; loc_pkt = '0; src_gcid = '0; loc_gcid = '0; src_life = '0;
        loc_valid = 1'b0; loc_dirty = 1'b0; bp = 1'b0;
    endtask

    initial begin
        vecs[0] = '{5'd0,  9'h000, 8'd0,  1'b1, 1'b0, 1'b0, 9'h000, 8'd1,
                    1'b1, 5'd13, 9'h000, 8'd1,  1'b1, 9'h000, 8'd1};
        vecs[1] = '{5'd0,  9'h000, 8'd0,  1'b1, 1'b1, 1'b0, 9'h002, 8'd2,
                    1'b0, 5'd0,  9'h000, 8'd0,  1'b0, 9'h000, 8'd1};
        vecs[2] = '{5'd10, 9'h1FF, 8'd5,  1'b1, 1'b0, 1'b0, 9'h000, 8'd6,
                    1'b0, 5'd9,  9'h1FF, 8'd5,  !HALF, HALF ? 9'h000 : 9'h1FF, HALF ? 8'd1 : 8'd5};
        vecs[3] = '{5'd1,  9'h0C0, 8'd7,  1'b1, 1'b0, 1'b0, 9'h001, 8'd8,
                    1'b0, 5'd0,  9'h0C0, 8'd7,  1'b0, HALF ? 9'h000 : 9'h1FF, HALF ? 8'd1 : 8'd5};
        vecs[4] = '{5'd0,  9'h000, 8'd0,  1'b1, 1'b0, 1'b0, 9'h001, 8'd8,
                    1'b1, 5'd13, 9'h001, 8'd8,  1'b1, 9'h001, 8'd8};
        vecs[5] = '{5'd0,  9'h000, 8'd0,  1'b1, 1'b0, 1'b1, 9'h001, 8'd8,
                    1'b0, 5'd0,  9'h000, 8'd0,  1'b0, 9'h001, 8'd8};
        vecs[6] = '{5'd5,  9'h008, 8'd9,  1'b1, 1'b0, 1'b1, 9'h001, 8'd8,
                    1'b0, 5'd4,  9'h008, 8'd9,  1'b1, 9'h008, 8'd9};
        vecs[7] = '{5'd2,  9'h1C0, 8'd10, 1'b0, 1'b0, 1'b0, 9'h000, 8'd0,
                    1'b0, 5'd1,  9'h1C0, 8'd10, !HALF, HALF ? 9'h008 : 9'h1C0, HALF ? 8'd9 : 8'd10};
        vecs[8] = '{5'd3,  9'h080, 8'd11, 1'b1, 1'b0, 1'b0, 9'h002, 8'd3,
                    1'b0, 5'd2,  9'h080, 8'd11, 1'b0, HALF ? 9'h008 : 9'h1C0, HALF ? 8'd9 : 8'd10};

        rst = 1'b1;
        drive_zero();
        for (int i = 0; i < 10; i++) step("reset");
        check("reset/fb_idle", 128'(o_dirty_feedback), 128'(0));

        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            src_life  = vecs[i].src_life;
            src_gcid  = vecs[i].src_gcid;
            src_pkt   = mk_pkt(4, 5, 6, vecs[i].src_parid);
            loc_valid = vecs[i].loc_valid;
            loc_dirty = vecs[i].loc_dirty;
            bp        = vecs[i].bp;
            loc_gcid  = vecs[i].loc_gcid;
            loc_pkt   = mk_pkt(1, 2, 3, vecs[i].loc_parid);
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d/tbl_fb", i),       128'(obs_fb),                         128'(vecs[i].exp_fb));
            check($sformatf("vec%0d/tbl_life", i),     128'(o_lifetime_to_ring),             128'(vecs[i].exp_life));
            check($sformatf("vec%0d/tbl_gcid", i),     128'(o_gcid_to_ring),                 128'(vecs[i].exp_gcid));
            check($sformatf("vec%0d/tbl_parid", i),    128'(o_offset_pkt_to_ring[PW+1:2]),   128'(vecs[i].exp_parid));
            check($sformatf("vec%0d/tbl_pev", i),      128'(o_pos_pkt_to_pe_valid),          128'(vecs[i].exp_pev));
            check($sformatf("vec%0d/tbl_pe_gcid", i),  128'(o_pos_pkt_to_pe[PPW-1:OPW]),     128'(vecs[i].exp_pe_gcid));
            check($sformatf("vec%0d/tbl_pe_parid", i), 128'(o_pos_pkt_to_pe[PW+1:2]),        128'(vecs[i].exp_pe_parid));
        end

        // Reset while a packet is in flight and a clean local entry is waiting.
        drive_zero();
        src_life = 5'd6; src_gcid = 9'h000; src_pkt = mk_pkt(7, 8, 9, 8'd12);
        step("midrst_pre");
        check("midrst_pre/life", 128'(o_lifetime_to_ring), 128'(5));
        rst = 1'b1;
        src_life = 5'd0; loc_valid = 1'b1; loc_pkt = mk_pkt(1, 1, 1, 8'd13);
        step("midrst");
        check("midrst/fb",       128'(obs_fb),                128'(0));
        check("midrst/life",     128'(o_lifetime_to_ring),    128'(0));
        check("midrst/pe_valid", 128'(o_pos_pkt_to_pe_valid), 128'(0));
        check("midrst/pe_pkt",   128'(o_pos_pkt_to_pe),       128'(0));
        rst = 1'b0;
        step("midrst_post");
        check("midrst_post/life", 128'(o_lifetime_to_ring), 128'(LIFE_INIT));

        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 199) == 0);
            src_life  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            src_gcid  = {rand_coord(), rand_coord(), rand_coord()};
            src_pkt   = rand_pkt();
            loc_gcid  = {rand_coord(), rand_coord(), rand_coord()};
            loc_pkt   = rand_pkt();
            loc_valid = 1'($urandom_range(0, 1));
            loc_dirty = ($urandom_range(0, 3) == 0);
            bp        = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
